// File: rtl/mem_stage_sram_ctrl.sv
// ---------------------------------------------------------------------------
// mem_stage_sram_ctrl
//   Memory stage of the 5-stage pipeline, between EX/MEM and MEM/WB.
//   Turns a load/store into a multi-cycle request/ready handshake with an
//   external SRAM controller. It stalls the upstream pipeline while an access
//   is in flight and holds the MEM/WB pipeline register.
//
// Ports
//   clk, rst          : rising-edge clock, asynchronous active-high reset
//   MEM_R_EN/MEM_W_EN : load / store in this stage (store wins if both set)
//   WB_EN_in, dest_in : write-back enable and destination register
//   ALU_res, ST_value : byte address (or ALU result) and store data
//   mem_req/mem_we    : request and direction to the SRAM controller
//   mem_addr/mem_wdata: word address and write data
//   mem_rdata/mem_ready: read data and one-cycle completion pulse
//   freeze            : stall for PC, IF/ID, ID/EX and EX/MEM
//   mem_err           : sticky timeout flag, cleared only by rst
//   *_out             : MEM/WB pipeline register
// ---------------------------------------------------------------------------
module mem_stage_sram_ctrl #(
    parameter int WORD_LEN       = 32,
    parameter int MEM_ADDR_LEN   = 16,
    parameter int ADDR_BASE      = 1024,
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    MEM_R_EN,
    input  logic                    MEM_W_EN,
    input  logic                    WB_EN_in,
    input  logic [4:0]              dest_in,
    input  logic [WORD_LEN-1:0]     ALU_res,
    input  logic [WORD_LEN-1:0]     ST_value,
    output logic                    mem_req,
    output logic                    mem_we,
    output logic [MEM_ADDR_LEN-1:0] mem_addr,
    output logic [WORD_LEN-1:0]     mem_wdata,
    input  logic [WORD_LEN-1:0]     mem_rdata,
    input  logic                    mem_ready,
    output logic                    freeze,
    output logic                    mem_err,
    output logic                    WB_EN_out,
    output logic                    MEM_R_EN_out,
    output logic [4:0]              dest_out,
    output logic [WORD_LEN-1:0]     ALU_res_out,
    output logic [WORD_LEN-1:0]     MEM_res_out
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_e;

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [WORD_LEN-1:0]   rdata_q, rdata_d;
    logic                  err_q, err_d;
    logic                  wb_en_q, wb_en_d;
    logic                  mem_r_en_q, mem_r_en_d;
    logic [4:0]            dest_q, dest_d;
    logic [WORD_LEN-1:0]   alu_res_q, alu_res_d;
    logic [WORD_LEN-1:0]   mem_res_q, mem_res_d;

    logic                  acc;
    logic                  is_read;
    logic                  req_c;
    logic                  freeze_c;
    logic [WORD_LEN-1:0]   addr_off;

    assign acc      = MEM_R_EN | MEM_W_EN;
    assign is_read  = MEM_R_EN & ~MEM_W_EN;
    assign addr_off = ALU_res - WORD_LEN'(ADDR_BASE);

    assign mem_addr  = MEM_ADDR_LEN'(addr_off >> 2);
    assign mem_wdata = ST_value;
    assign mem_we    = MEM_W_EN;

    // Request and stall are combinational so a new access stalls the
    // pipeline in its first IDLE cycle; rst forces both low immediately.
    assign mem_req = req_c & ~rst;
    assign freeze  = freeze_c & ~rst;
    assign mem_err = err_q;

    assign WB_EN_out    = wb_en_q;
    assign MEM_R_EN_out = mem_r_en_q;
    assign dest_out     = dest_q;
    assign ALU_res_out  = alu_res_q;
    assign MEM_res_out  = mem_res_q;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
        req_c    = 1'b0;
        freeze_c = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (acc) begin
                    req_c    = 1'b1;
                    freeze_c = 1'b1;
                    cnt_d    = '0;
                    state_d  = BUSY;
                end
            end
            BUSY: begin
                req_c    = 1'b1;
                freeze_c = 1'b1;
                // A ready on the last allowed cycle still completes normally.
                if (mem_ready) begin
                    if (is_read) begin
                        rdata_d = mem_rdata;
                    end
                    state_d = DONE;
                end else if (cnt_q == CNT_LAST) begin
                    err_d   = 1'b1;
                    rdata_d = '0;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // MEM/WB: a stall inserts a bubble (control bits cleared, data held).
        wb_en_d    = wb_en_q;
        mem_r_en_d = mem_r_en_q;
        dest_d     = dest_q;
        alu_res_d  = alu_res_q;
        mem_res_d  = mem_res_q;
        if (freeze_c) begin
            wb_en_d    = 1'b0;
            mem_r_en_d = 1'b0;
        end else begin
            wb_en_d    = WB_EN_in;
            mem_r_en_d = is_read;
            dest_d     = dest_in;
            alu_res_d  = ALU_res;
            mem_res_d  = (state_q == DONE && is_read) ? rdata_q : '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
            wb_en_q    <= 1'b0;
            mem_r_en_q <= 1'b0;
            dest_q     <= '0;
            alu_res_q  <= '0;
            mem_res_q  <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rdata_q    <= rdata_d;
            err_q      <= err_d;
            wb_en_q    <= wb_en_d;
            mem_r_en_q <= mem_r_en_d;
            dest_q     <= dest_d;
            alu_res_q  <= alu_res_d;
            mem_res_q  <= mem_res_d;
        end
    end

endmodule

// File: tb/tb_mem_stage_sram_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mem_stage_sram_ctrl
//   Drives one instruction at a time through the memory stage, acting as the
//   upstream pipeline (inputs change only after the stage un-freezes) and as
//   the SRAM controller (mem_ready after a chosen number of BUSY cycles).
//   Expected values come from a per-instruction outcome model.
// ---------------------------------------------------------------------------
module tb_mem_stage_sram_ctrl;

    localparam int TIMEOUT = 15;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        MEM_R_EN = 1'b0, MEM_W_EN = 1'b0, WB_EN_in = 1'b0;
    logic [4:0]  dest_in = '0;
    logic [31:0] ALU_res = '0, ST_value = '0, mem_rdata = '0;
    logic        mem_ready = 1'b0;
    logic        mem_req, mem_we, freeze, mem_err;
    logic [15:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        WB_EN_out, MEM_R_EN_out;
    logic [4:0]  dest_out;
    logic [31:0] ALU_res_out, MEM_res_out;

    mem_stage_sram_ctrl #(
        .WORD_LEN(32),
        .MEM_ADDR_LEN(16),
        .ADDR_BASE(1024),
        .TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst),
        .MEM_R_EN(MEM_R_EN), .MEM_W_EN(MEM_W_EN), .WB_EN_in(WB_EN_in),
        .dest_in(dest_in), .ALU_res(ALU_res), .ST_value(ST_value),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .freeze(freeze), .mem_err(mem_err),
        .WB_EN_out(WB_EN_out), .MEM_R_EN_out(MEM_R_EN_out), .dest_out(dest_out),
        .ALU_res_out(ALU_res_out), .MEM_res_out(MEM_res_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          r, w, wb;
        logic [4:0]  dest;
        logic [31:0] alu, st, rdata;
        int          lat;   // ready on this BUSY cycle (1-based); 0 = never
    } op_t;

    int n_vec = 0;
    int n_err = 0;

    // Model state: last retired op's data fields and the sticky error.
    logic [4:0]  m_dest = '0;
    logic [31:0] m_alu  = '0;
    bit          m_err  = 0;

    // Model outputs for the current op.
    int          e_fz;
    bit          e_to;
    logic [31:0] e_memres;
    logic [15:0] e_addr;

    // Observations from the driver.
    int          o_fz;
    logic        o_req, o_we, o_done_req;
    logic [15:0] o_addr;
    logic [31:0] o_wdata;
    int          o_bad;
    logic        o_wb, o_mre, o_err;
    logic [4:0]  o_dest;
    logic [31:0] o_alu, o_memres;

    function automatic void model(input op_t op);
        bit mem = op.r | op.w;
        e_to     = mem && (op.lat <= 0 || op.lat > TIMEOUT);
        e_fz     = !mem ? 0 : (e_to ? TIMEOUT + 1 : op.lat + 1);
        e_memres = (op.r && !op.w && !e_to) ? op.rdata : 32'h0;
        e_addr   = 16'((op.alu - 32'd1024) >> 2);
        m_err    = m_err | e_to;
    endfunction

    // Called at a negedge; returns at the negedge after the op retires.
    task automatic do_op(input op_t op);
        int k;
        MEM_R_EN = op.r; MEM_W_EN = op.w; WB_EN_in = op.wb;
        dest_in = op.dest; ALU_res = op.alu; ST_value = op.st;
        mem_ready = 1'b0; mem_rdata = $urandom;
        #1;
        o_req = mem_req; o_we = mem_we; o_addr = mem_addr; o_wdata = mem_wdata;
        o_fz = 0; o_bad = 0; k = 0;
        while (freeze === 1'b1 && k < 40) begin
            o_fz++;
            @(negedge clk);
            k++;
            mem_ready = (k == op.lat);
            mem_rdata = (k == op.lat) ? op.rdata : $urandom;
            #1;
            if (freeze === 1'b1 && mem_req !== 1'b1) o_bad++;
            if (WB_EN_out !== 1'b0 || MEM_R_EN_out !== 1'b0 ||
                dest_out !== m_dest || ALU_res_out !== m_alu) o_bad++;
        end
        o_done_req = mem_req;
        @(negedge clk);
        mem_ready = 1'b0;
        #1;
        o_wb = WB_EN_out; o_mre = MEM_R_EN_out; o_dest = dest_out;
        o_alu = ALU_res_out; o_memres = MEM_res_out; o_err = mem_err;
        m_dest = op.dest; m_alu = op.alu;
    endtask

    function automatic op_t mk(bit r, bit w, bit wb, logic [4:0] d, logic [31:0] a,
                               logic [31:0] s, logic [31:0] rd, int lat);
        op_t o;
        o.r = r; o.w = w; o.wb = wb; o.dest = d; o.alu = a; o.st = s;
        o.rdata = rd; o.lat = lat;
        return o;
    endfunction

    task automatic test_reset;
        @(negedge clk); #1;
        n_vec++;
        if ({mem_req, freeze, mem_err, WB_EN_out, MEM_R_EN_out, dest_out, ALU_res_out, MEM_res_out} !== '0) begin
            n_err++;
            $display("FAIL reset_state: got req=%b frz=%b err=%b wb=%b mre=%b dest=%0d alu=%h mres=%h, want all 0",
                     mem_req, freeze, mem_err, WB_EN_out, MEM_R_EN_out, dest_out, ALU_res_out, MEM_res_out);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_nonmem;
        op_t op = mk(0, 0, 1, 5'd5, 32'h2A, 32'h0, 32'h0, 0);
        model(op); do_op(op);
        n_vec++;
        if ({o_fz, o_req, o_done_req} !== {32'd0, 1'b0, 1'b0}) begin
            n_err++; $display("FAIL nonmem_freeze: got fz=%0d req=%b, want 0 0", o_fz, o_req);
        end
        n_vec++;
        if ({o_wb, o_mre, o_dest, o_alu, o_memres} !== {1'b1, 1'b0, 5'd5, 32'h2A, 32'h0}) begin
            n_err++; $display("FAIL nonmem_wb: got wb=%b mre=%b dest=%0d alu=%h mres=%h, want 1 0 5 2a 0",
                              o_wb, o_mre, o_dest, o_alu, o_memres);
        end
    endtask

    task automatic test_load;
        op_t op = mk(1, 0, 1, 5'd9, 32'd1032, 32'h0, 32'hDEADBEEF, 3);
        model(op); do_op(op);
        n_vec++;
        if ({o_req, o_we, o_addr} !== {1'b1, 1'b0, 16'd2}) begin
            n_err++; $display("FAIL load_req: got req=%b we=%b addr=%0d, want 1 0 2", o_req, o_we, o_addr);
        end
        n_vec++;
        if (o_fz !== 4 || o_bad !== 0 || o_done_req !== 1'b0) begin
            n_err++; $display("FAIL load_freeze: got fz=%0d bad=%0d done_req=%b, want 4 0 0", o_fz, o_bad, o_done_req);
        end
        n_vec++;
        if ({o_wb, o_mre, o_dest, o_memres} !== {1'b1, 1'b1, 5'd9, 32'hDEADBEEF}) begin
            n_err++; $display("FAIL load_wb: got wb=%b mre=%b dest=%0d mres=%h, want 1 1 9 deadbeef",
                              o_wb, o_mre, o_dest, o_memres);
        end
    endtask

    task automatic test_store;
        op_t op = mk(0, 1, 0, 5'd3, 32'd1024, 32'h55, 32'h12345678, 1);
        model(op); do_op(op);
        n_vec++;
        if ({o_req, o_we, o_addr, o_wdata} !== {1'b1, 1'b1, 16'd0, 32'h55}) begin
            n_err++; $display("FAIL store_req: got req=%b we=%b addr=%0d wdata=%h, want 1 1 0 55",
                              o_req, o_we, o_addr, o_wdata);
        end
        n_vec++;
        if (o_fz !== 2 || o_bad !== 0) begin
            n_err++; $display("FAIL store_freeze: got fz=%0d bad=%0d, want 2 0", o_fz, o_bad);
        end
        n_vec++;
        if ({o_wb, o_mre, o_memres} !== {1'b0, 1'b0, 32'h0}) begin
            n_err++; $display("FAIL store_wb: got wb=%b mre=%b mres=%h, want 0 0 0", o_wb, o_mre, o_memres);
        end
    endtask

    task automatic test_back_to_back;
        op_t ops[2];
        ops[0] = mk(1, 0, 1, 5'd7, 32'd1024 + 32'd40, 32'h0, $urandom, 1);
        ops[1] = mk(0, 1, 0, 5'd8, 32'd1024 + 32'd44, $urandom, $urandom, 1);
        foreach (ops[i]) begin
            model(ops[i]); do_op(ops[i]);
            n_vec++;
            if (o_fz !== 2 || o_bad !== 0 || o_done_req !== 1'b0 || o_addr !== e_addr) begin
                n_err++; $display("FAIL b2b_seq[%0d]: got fz=%0d bad=%0d done_req=%b addr=%0d, want 2 0 0 %0d",
                                  i, o_fz, o_bad, o_done_req, o_addr, e_addr);
            end
            n_vec++;
            if ({o_wb, o_mre, o_dest, o_memres} !== {ops[i].wb, ops[i].r, ops[i].dest, e_memres}) begin
                n_err++; $display("FAIL b2b_wb[%0d]: got wb=%b mre=%b dest=%0d mres=%h, want %b %b %0d %h",
                                  i, o_wb, o_mre, o_dest, o_memres, ops[i].wb, ops[i].r, ops[i].dest, e_memres);
            end
        end
    endtask

    // Random mix including both-enables and the ready-on-last-cycle boundary.
    task automatic test_random(input int n, input bit allow_timeout);
        for (int i = 0; i < n; i++) begin
            op_t op;
            int  sel = $urandom_range(0, 3);
            op = mk(sel == 1 || sel == 3, sel == 2 || sel == 3, $urandom_range(0, 1),
                    5'($urandom), 32'd1024 + $urandom_range(0, 32'hFFFFF), $urandom, $urandom,
                    $urandom_range(1, 6));
            if (i % 7 == 3) op.lat = TIMEOUT;
            if (allow_timeout && i % 5 == 1) op.lat = 0;
            model(op); do_op(op);
            n_vec++;
            if (o_fz !== e_fz || o_bad !== 0 || o_done_req !== 1'b0) begin
                n_err++; $display("FAIL rnd_seq[%0d]: got fz=%0d bad=%0d done_req=%b, want %0d 0 0",
                                  i, o_fz, o_bad, o_done_req, e_fz);
            end
            if (op.r | op.w) begin
                n_vec++;
                if ({o_req, o_we, o_addr, o_wdata} !== {1'b1, op.w, e_addr, op.st}) begin
                    n_err++; $display("FAIL rnd_req[%0d]: got we=%b addr=%h wdata=%h, want %b %h %h",
                                      i, o_we, o_addr, o_wdata, op.w, e_addr, op.st);
                end
            end
            n_vec++;
            if ({o_wb, o_mre, o_dest, o_alu, o_memres, o_err} !==
                {op.wb, op.r & ~op.w, op.dest, op.alu, e_memres, m_err}) begin
                n_err++; $display("FAIL rnd_wb[%0d]: got wb=%b mre=%b dest=%0d alu=%h mres=%h err=%b, want %b %b %0d %h %h %b",
                                  i, o_wb, o_mre, o_dest, o_alu, o_memres, o_err,
                                  op.wb, op.r & ~op.w, op.dest, op.alu, e_memres, m_err);
            end
        end
    endtask

    task automatic test_timeout;
        op_t op = mk(1, 0, 1, 5'd12, 32'd1024 + 32'd100, 32'h0, 32'hCAFEF00D, 0);
        n_vec++;
        if (mem_err !== 1'b0) begin
            n_err++; $display("FAIL err_before_timeout: got %b, want 0", mem_err);
        end
        model(op); do_op(op);
        n_vec++;
        if (o_fz !== TIMEOUT + 1 || o_bad !== 0) begin
            n_err++; $display("FAIL timeout_freeze: got fz=%0d bad=%0d, want %0d 0", o_fz, o_bad, TIMEOUT + 1);
        end
        n_vec++;
        if ({o_err, o_wb, o_memres} !== {1'b1, 1'b1, 32'h0}) begin
            n_err++; $display("FAIL timeout_wb: got err=%b wb=%b mres=%h, want 1 1 0", o_err, o_wb, o_memres);
        end
    endtask

    task automatic test_reset_mid_access;
        MEM_R_EN = 1'b1; MEM_W_EN = 1'b0; WB_EN_in = 1'b1; dest_in = 5'd4;
        ALU_res = 32'd1028; mem_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        n_vec++;
        if ({mem_req, freeze, mem_err, WB_EN_out, MEM_R_EN_out, dest_out, ALU_res_out, MEM_res_out} !== '0) begin
            n_err++; $display("FAIL rst_mid: got req=%b frz=%b err=%b wb=%b dest=%0d alu=%h mres=%h, want all 0",
                              mem_req, freeze, mem_err, WB_EN_out, dest_out, ALU_res_out, MEM_res_out);
        end
        @(negedge clk);
        rst = 1'b0; m_err = 0; m_dest = '0; m_alu = '0;
        MEM_R_EN = 1'b0; WB_EN_in = 1'b0; dest_in = '0; ALU_res = '0; ST_value = '0;
        @(negedge clk);
        mem_ready = 1'b1; mem_rdata = 32'hBADBAD00;
        #1;
        n_vec++;
        if ({mem_req, freeze} !== 2'b00) begin
            n_err++; $display("FAIL late_ready: got req=%b frz=%b, want 0 0", mem_req, freeze);
        end
        @(negedge clk);
        mem_ready = 1'b0;
        #1;
        n_vec++;
        if ({mem_err, WB_EN_out, MEM_R_EN_out, dest_out, ALU_res_out, MEM_res_out} !== '0) begin
            n_err++; $display("FAIL after_rst_wb: got err=%b wb=%b mre=%b dest=%0d alu=%h mres=%h, want all 0",
                              mem_err, WB_EN_out, MEM_R_EN_out, dest_out, ALU_res_out, MEM_res_out);
        end
        begin
            op_t op = mk(1, 0, 1, 5'd6, 32'd1036, 32'h0, 32'h0BADCAFE, 2);
            model(op); do_op(op);
            n_vec++;
            if (o_fz !== 3 || o_memres !== 32'h0BADCAFE || o_err !== 1'b0) begin
                n_err++; $display("FAIL post_rst_load: got fz=%0d mres=%h err=%b, want 3 0badcafe 0",
                                  o_fz, o_memres, o_err);
            end
        end
    endtask

    initial begin
        test_reset;
        test_nonmem;
        test_load;
        test_store;
        test_back_to_back;
        test_random(40, 1'b0);
        test_timeout;
        test_random(15, 1'b1);
        test_reset_mid_access;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/mem_stage_sram_ctrl.md
Name: mem_stage_sram_ctrl

Overview:
- Memory stage of the 5-stage pipeline. It sits directly downstream of the EXE stage.
- It consumes the EX/MEM-registered ALU result (used as the address) and the store value, and runs a multi-cycle handshake with an external SRAM controller.
- It freezes the upstream pipeline while an access is in flight.
- It contains the MEM/WB pipeline register that feeds write-back.

Parameters:
WORD_LEN, 32, data/address word width
MEM_ADDR_LEN, 16, word-address width driven to the SRAM controller
ADDR_BASE, 1024, byte address mapped to memory word 0
TIMEOUT_CYCLES, 15, maximum BUSY cycles before the access is abandoned

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
MEM_R_EN  in  1  load in the MEM stage
MEM_W_EN  in  1  store in the MEM stage
WB_EN_in  in  1  register write-back enable
dest_in  in  5  destination register
ALU_res  in  WORD_LEN  byte address, or the ALU result for non-memory ops
ST_value  in  WORD_LEN  store data
mem_req  out  1  request to the SRAM controller
mem_we  out  1  1 = write, 0 = read
mem_addr  out  MEM_ADDR_LEN  word address
mem_wdata  out  WORD_LEN  write data
mem_rdata  in  WORD_LEN  read data, valid when mem_ready=1
mem_ready  in  1  one-cycle completion pulse from the SRAM controller
freeze  out  1  stall for PC, IF/ID, ID/EX and EX/MEM
mem_err  out  1  sticky timeout flag
WB_EN_out  out  1  MEM/WB: write-back enable
MEM_R_EN_out  out  1  MEM/WB: result selects memory data
dest_out  out  5  MEM/WB: destination register
ALU_res_out  out  WORD_LEN  MEM/WB: ALU result
MEM_res_out  out  WORD_LEN  MEM/WB: load data

Behaviour:
- acc = MEM_R_EN | MEM_W_EN. If both are set, the access is a write and MEM_R_EN_out is captured as 0.
- mem_addr = (ALU_res - ADDR_BASE) >> 2, truncated to MEM_ADDR_LEN. Low two address bits are ignored.
- mem_wdata = ST_value. mem_we = MEM_W_EN.
- FSM states: IDLE, BUSY, DONE. A wait counter runs in BUSY.
- IDLE:
  - If acc=1: mem_req=1 and freeze=1 combinationally in the same cycle; next state BUSY; counter cleared.
  - Otherwise the stage is transparent (freeze=0, mem_req=0).
  - mem_ready is ignored in IDLE.
- BUSY:
  - mem_req=1 and freeze=1. Upstream inputs are stable because the EX/MEM register is frozen.
  - If mem_ready=1: capture mem_rdata into rdata_q (reads only); go to DONE.
  - Else if counter = TIMEOUT_CYCLES-1: set mem_err=1, rdata_q=0, go to DONE.
  - Else increment the counter.
- DONE:
  - mem_req=0 and freeze=0; the pipeline advances at this edge; next state IDLE.
  - A memory op arriving in the following IDLE cycle starts a new access. Back-to-back accesses are therefore never overlapped.
- Minimum memory-op occupancy is 3 cycles (IDLE, BUSY with mem_ready, DONE). A non-memory op takes 1 cycle.
- MEM/WB register update, each rising edge:
  - When freeze=0: WB_EN_out <= WB_EN_in, MEM_R_EN_out <= MEM_R_EN & ~MEM_W_EN, dest_out <= dest_in, ALU_res_out <= ALU_res, MEM_res_out <= (state==DONE & read) ? rdata_q : 0.
  - When freeze=1: a bubble is inserted. WB_EN_out <= 0 and MEM_R_EN_out <= 0; the other MEM/WB fields hold their values.
- mem_err is sticky and is cleared only by rst.
- Reset (asynchronous, any state):
  - state=IDLE, counter=0, rdata_q=0, mem_err=0.
  - All MEM/WB outputs are 0.
  - mem_req and freeze drop to 0 immediately. An in-flight request is abandoned.
  - A mem_ready arriving after reset is ignored.

Test Plan:
1. Non-memory op: ALU_res=0x2A, WB_EN_in=1, dest_in=5, no mem enables -> freeze=0 throughout; next edge gives ALU_res_out=0x2A, dest_out=5, WB_EN_out=1, MEM_res_out=0.
2. Load:
   - Stimulus: ALU_res=1032, MEM_R_EN=1; mem_ready pulsed 3 cycles later with mem_rdata=0xDEADBEEF.
   - Response: mem_addr=2 and mem_we=0; freeze=1 for 4 cycles with WB_EN_out=0 while frozen; then MEM_res_out=0xDEADBEEF, MEM_R_EN_out=1, WB_EN_out=1.
3. Store:
   - Stimulus: ALU_res=1024, ST_value=0x55, MEM_W_EN=1, WB_EN_in=0; mem_ready in the first BUSY cycle.
   - Response: mem_we=1, mem_addr=0, mem_wdata=0x55; freeze=1 for exactly 2 cycles; WB_EN_out=0, MEM_res_out=0.
4. Timeout: load with mem_ready held at 0 -> after 15 BUSY cycles mem_err=1, MEM_res_out=0, and the pipeline resumes; mem_err stays 1 until rst.
5. Back-to-back: load followed by store, each acked with 1-cycle latency -> two separate IDLE-BUSY-DONE sequences; mem_req is low during each DONE cycle; both results appear in order.
6. Reset mid-access: assert rst in BUSY, then pulse mem_ready after release -> mem_req and freeze are 0 immediately on rst; state is IDLE; the late mem_ready is ignored; all MEM/WB outputs are 0.
